// File: rtl/serial_xfer_ctrl.sv
// Serial transaction sequencer: collects a serial address and optional write data, performs one memory access, and returns read data serially.
// Optional parity check stage enabled by defining SERIAL_XFER_PARITY_EN.
module serial_xfer_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Active,
  input  logic              Mode,
  input  logic              InputKey,
  input  logic              ValidCmd,
  input  logic [DATA_W-1:0] MemRdData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWrData,
  output logic              MemWrEn,
  output logic              MemRdEn,
  output logic              Busy,
  output logic              DataOut,
  output logic              ValidOut,
  output logic              Done,
  output logic              Err
);

  localparam int unsigned MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned CNT_W = $clog2(MAX_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_PAR,
    S_ACCESS,
    S_RWAIT,
    S_SHOUT,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wr_data_q, mem_wr_data_d;
  logic                mode_q, mode_d;
  logic                par_q, par_d;
  state_e              after_bits;

`ifdef SERIAL_XFER_PARITY_EN
  logic                err_q, err_d;
  assign after_bits = S_PAR;
`else
  assign after_bits = S_ACCESS;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    data_d        = data_q;
    out_d         = out_q;
    mode_d        = mode_q;
    par_d         = par_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
`ifdef SERIAL_XFER_PARITY_EN
    err_d         = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (Active) begin
          mode_d  = Mode;
          cnt_d   = '0;
          par_d   = 1'b0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (ValidCmd) begin
          addr_d = {addr_q[ADDR_W-2:0], InputKey};
          par_d  = par_q ^ InputKey;
          if (cnt_q == CNT_W'(ADDR_W - 1)) begin
            cnt_d   = '0;
            state_d = mode_q ? S_DATA : after_bits;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (ValidCmd) begin
          data_d = {data_q[DATA_W-2:0], InputKey};
          par_d  = par_q ^ InputKey;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            cnt_d   = '0;
            state_d = after_bits;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_PAR: begin
`ifdef SERIAL_XFER_PARITY_EN
        // par_q holds the running XOR of every bit consumed so far
        if (ValidCmd) begin
          if (par_q ^ InputKey) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_ACCESS;
          end
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_ACCESS: state_d = mode_q ? S_DONE : S_RWAIT;
      S_RWAIT: begin
        out_d   = MemRdData;
        cnt_d   = '0;
        state_d = S_SHOUT;
      end
      S_SHOUT: begin
        out_d = {out_q[DATA_W-2:0], 1'b0};
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Memory address/data are loaded on the edge entering ACCESS so they are stable with the strobe
    if (state_d == S_ACCESS && state_q != S_ACCESS) begin
      mem_addr_d    = addr_d;
      mem_wr_data_d = data_d;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      out_q         <= '0;
      mode_q        <= 1'b0;
      par_q         <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      out_q         <= out_d;
      mode_q        <= mode_d;
      par_q         <= par_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
    end
  end

`ifdef SERIAL_XFER_PARITY_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

  assign MemAddr   = mem_addr_q;
  assign MemWrData = mem_wr_data_q;
  assign MemWrEn   = (state_q == S_ACCESS) && mode_q;
  assign MemRdEn   = (state_q == S_ACCESS) && !mode_q;
  assign Busy      = (state_q != S_IDLE);
  assign ValidOut  = (state_q == S_SHOUT);
  assign DataOut   = (state_q == S_SHOUT) && out_q[DATA_W-1];
  assign Done      = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_xfer_ctrl.sv
// Directed self-checking bench for serial_xfer_ctrl with ADDR_W = DATA_W = 8.
module tb_serial_xfer_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Active;
  logic       Mode;
  logic       InputKey;
  logic       ValidCmd;
  logic [7:0] MemRdData = 8'h00;
  logic [7:0] MemAddr;
  logic [7:0] MemWrData;
  logic       MemWrEn;
  logic       MemRdEn;
  logic       Busy;
  logic       DataOut;
  logic       ValidOut;
  logic       Done;
  logic       Err;

  logic [7:0] rd_word = 8'h00;
  int         n_cmp = 0;
  int         n_err = 0;

  serial_xfer_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .Active(Active), .Mode(Mode),
    .InputKey(InputKey), .ValidCmd(ValidCmd), .MemRdData(MemRdData),
    .MemAddr(MemAddr), .MemWrData(MemWrData), .MemWrEn(MemWrEn),
    .MemRdEn(MemRdEn), .Busy(Busy), .DataOut(DataOut), .ValidOut(ValidOut),
    .Done(Done), .Err(Err)
  );

  always #5 Clk = ~Clk;

  // Memory returns its word one cycle after the read strobe
  always @(posedge Clk) if (MemRdEn) MemRdData <= rd_word;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] v, input bit stall, input bit last);
    for (int i = 7; i >= 0; i--) begin
      ValidCmd = 1'b1;
      InputKey = v[i];
      tick();
      if (stall && !(last && i == 0)) begin
        ValidCmd = 1'b0;
        InputKey = ~v[i];
        tick();
        chk("stall_busy_a", Busy, 1);
        tick();
        chk("stall_busy_b", Busy, 1);
      end
    end
    ValidCmd = 1'b0;
    InputKey = 1'b0;
  endtask

  task automatic send_parity(input logic [7:0] a, input logic [7:0] d, input bit wr);
`ifdef SERIAL_XFER_PARITY_EN
    ValidCmd = 1'b1;
    InputKey = (^a) ^ (wr ? (^d) : 1'b0);
    tick();
    ValidCmd = 1'b0;
    InputKey = 1'b0;
`else
    if (wr && a == 8'hFF && d == 8'hFF) InputKey = 1'b0;
`endif
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input bit stall);
    Active = 1'b1;
    Mode   = 1'b1;
    tick();
    chk("wr_busy_rise", Busy, 1);
    Active = 1'b0;
    Mode   = 1'b0;
    send_bits(a, stall, 1'b0);
    send_bits(d, stall, 1'b1);
    send_parity(a, d, 1'b1);
    chk("wr_wren", MemWrEn, 1);
    chk("wr_rden", MemRdEn, 0);
    chk("wr_addr", MemAddr, a);
    chk("wr_data", MemWrData, d);
    chk("wr_done_early", Done, 0);
    tick();
    chk("wr_done", Done, 1);
    chk("wr_wren_off", MemWrEn, 0);
    chk("wr_err", Err, 0);
    chk("wr_busy_done", Busy, 1);
    tick();
    chk("wr_done_off", Done, 0);
    chk("wr_busy_fall", Busy, 0);
  endtask

  // Starts in ADDR; ends during the Done cycle
  task automatic read_body(input logic [7:0] a, input logic [7:0] w);
    logic [7:0] exp_bits;
    exp_bits = w;
    rd_word  = w;
    send_bits(a, 1'b0, 1'b1);
    send_parity(a, 8'h00, 1'b0);
    chk("rd_rden", MemRdEn, 1);
    chk("rd_wren", MemWrEn, 0);
    chk("rd_addr", MemAddr, a);
    tick();
    chk("rd_rden_off", MemRdEn, 0);
    chk("rd_rwait_vo", ValidOut, 0);
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("rd_validout", ValidOut, 1);
      chk("rd_dataout", DataOut, exp_bits[7-k]);
      tick();
    end
    chk("rd_done", Done, 1);
    chk("rd_vo_off", ValidOut, 0);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] w);
    Active = 1'b1;
    Mode   = 1'b0;
    tick();
    chk("rd_busy_rise", Busy, 1);
    Active = 1'b0;
    read_body(a, w);
    tick();
    chk("rd_done_off", Done, 0);
    chk("rd_busy_fall", Busy, 0);
  endtask

  initial begin
    Reset    = 1'b0;
    Active   = 1'b0;
    Mode     = 1'b0;
    InputKey = 1'b0;
    ValidCmd = 1'b0;
    #12;
    chk("rst_busy", Busy, 0);
    chk("rst_wren", MemWrEn, 0);
    chk("rst_rden", MemRdEn, 0);
    chk("rst_done", Done, 0);
    chk("rst_vo", ValidOut, 0);
    chk("rst_dout", DataOut, 0);
    chk("rst_err", Err, 0);
    chk("rst_addr", MemAddr, 0);
    chk("rst_wdata", MemWrData, 0);
    @(negedge Clk);
    Reset = 1'b1;
    tick();
    chk("idle_busy", Busy, 0);

    do_write(8'hA5, 8'h3C, 1'b0);
    do_write(8'h5A, 8'hC3, 1'b1);
    do_read(8'h0F, 8'h96);

    // Reset in the middle of shifting out
    rd_word = 8'h3B;
    Active  = 1'b1;
    Mode    = 1'b0;
    tick();
    Active = 1'b0;
    send_bits(8'h81, 1'b0, 1'b1);
    send_parity(8'h81, 8'h00, 1'b0);
    tick();
    tick();
    chk("pre_rst_vo", ValidOut, 1);
    tick();
    tick();
    Reset = 1'b0;
    #1;
    chk("mid_rst_vo", ValidOut, 0);
    chk("mid_rst_dout", DataOut, 0);
    chk("mid_rst_busy", Busy, 0);
    chk("mid_rst_addr", MemAddr, 0);
    chk("mid_rst_done", Done, 0);
    @(negedge Clk);
    Reset = 1'b1;
    tick();
    do_read(8'h81, 8'h3B);

    // Back-to-back reads with Active held high
    Active = 1'b1;
    Mode   = 1'b0;
    tick();
    chk("b2b_busy1", Busy, 1);
    read_body(8'h42, 8'hC5);
    tick();
    chk("b2b_gap_busy", Busy, 0);
    chk("b2b_gap_done", Done, 0);
    tick();
    chk("b2b_busy2", Busy, 1);
    Active = 1'b0;
    read_body(8'h24, 8'h5A);
    tick();
    chk("b2b_end_busy", Busy, 0);

`ifdef SERIAL_XFER_PARITY_EN
    Active = 1'b1;
    Mode   = 1'b1;
    tick();
    Active = 1'b0;
    send_bits(8'h01, 1'b0, 1'b0);
    send_bits(8'h00, 1'b0, 1'b1);
    ValidCmd = 1'b1;
    InputKey = 1'b0;
    tick();
    ValidCmd = 1'b0;
    chk("par_err", Err, 1);
    chk("par_done", Done, 1);
    chk("par_wren", MemWrEn, 0);
    tick();
    chk("par_err_off", Err, 0);
    chk("par_busy", Busy, 0);
    do_write(8'h01, 8'h00, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
